// File: rtl/bus_dma_initiator.sv
// Single-channel word-copy DMA initiator: reads one 32-bit word from src, writes it to dst,
// repeats for len words, with per-request timeout and sticky fault reporting.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 3
`endif

module bus_dma_initiator #(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned LEN_W   = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic                            abort,
    input  logic [`XLEN-1:0]                src_addr,
    input  logic [`XLEN-1:0]                dst_addr,
    input  logic [LEN_W-1:0]                len,
    output logic                            busy,
    output logic                            done,
    output logic                            fault,
    output logic [LEN_W-1:0]                remaining,
    output logic [`XLEN-1:0]                p_addr,
    output logic                            p_w_rb,
    output logic [$clog2(`BUS_ACC_CNT)-1:0] p_acc,
    output logic [`BUS_WIDTH-1:0]           p_wdata,
    output logic                            p_req,
    input  logic [`BUS_WIDTH-1:0]           p_rdata,
    input  logic                            p_resp,
    input  logic                            p_fault
);

    localparam int unsigned ACC_W = $clog2(`BUS_ACC_CNT);
    localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [ACC_W-1:0] ACC_WORD = ACC_W'(2);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RD, GAP_W, WR, GAP_R, ERR} state_t;

    state_t                  state_q, state_d;
    logic                    busy_q, busy_d;
    logic                    done_q, done_d;
    logic                    fault_q, fault_d;
    logic [LEN_W-1:0]        remaining_q, remaining_d;
    logic [`XLEN-1:0]        p_addr_q, p_addr_d;
    logic                    p_w_rb_q, p_w_rb_d;
    logic [ACC_W-1:0]        p_acc_q, p_acc_d;
    logic [`BUS_WIDTH-1:0]   p_wdata_q, p_wdata_d;
    logic                    p_req_q, p_req_d;
    logic [`XLEN-1:0]        src_q, src_d;
    logic [`XLEN-1:0]        dst_q, dst_d;
    logic [`BUS_WIDTH-1:0]   buf_q, buf_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            remaining_q <= '0;
            p_addr_q    <= '0;
            p_w_rb_q    <= 1'b0;
            p_acc_q     <= '0;
            p_wdata_q   <= '0;
            p_req_q     <= 1'b0;
            src_q       <= '0;
            dst_q       <= '0;
            buf_q       <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            remaining_q <= remaining_d;
            p_addr_q    <= p_addr_d;
            p_w_rb_q    <= p_w_rb_d;
            p_acc_q     <= p_acc_d;
            p_wdata_q   <= p_wdata_d;
            p_req_q     <= p_req_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            buf_q       <= buf_d;
            cnt_q       <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        fault_d     = fault_q;
        remaining_d = remaining_q;
        p_addr_d    = p_addr_q;
        p_w_rb_d    = p_w_rb_q;
        p_acc_d     = p_acc_q;
        p_wdata_d   = p_wdata_q;
        p_req_d     = p_req_q;
        src_d       = src_q;
        dst_d       = dst_q;
        buf_d       = buf_q;
        cnt_d       = cnt_q;

        if (abort) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            fault_d = 1'b0;
            p_req_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        if (len == '0) begin
                            done_d = 1'b1;
                        end else if (src_addr[1:0] != 2'b00 || dst_addr[1:0] != 2'b00) begin
                            state_d = ERR;
                            fault_d = 1'b1;
                        end else begin
                            state_d     = RD;
                            busy_d      = 1'b1;
                            src_d       = src_addr;
                            dst_d       = dst_addr;
                            remaining_d = len;
                            p_req_d     = 1'b1;
                            p_w_rb_d    = 1'b0;
                            p_acc_d     = ACC_WORD;
                            p_addr_d    = src_addr;
                            cnt_d       = '0;
                        end
                    end
                end
                RD, WR: begin
                    if (p_resp) begin
                        p_req_d = 1'b0;
                        if (p_fault) begin
                            state_d = ERR;
                            busy_d  = 1'b0;
                            fault_d = 1'b1;
                        end else if (state_q == RD) begin
                            buf_d   = p_rdata;
                            state_d = GAP_W;
                        end else begin
                            remaining_d = remaining_q - 1'b1;
                            src_d       = src_q + `XLEN'(4);
                            dst_d       = dst_q + `XLEN'(4);
                            state_d     = GAP_R;
                        end
                    end else if (cnt_q == CNT_LAST) begin
                        state_d = ERR;
                        busy_d  = 1'b0;
                        fault_d = 1'b1;
                        p_req_d = 1'b0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                GAP_W: begin
                    state_d   = WR;
                    p_req_d   = 1'b1;
                    p_w_rb_d  = 1'b1;
                    p_addr_d  = dst_q;
                    p_wdata_d = buf_q;
                    cnt_d     = '0;
                end
                GAP_R: begin
                    if (remaining_q != '0) begin
                        state_d  = RD;
                        p_req_d  = 1'b1;
                        p_w_rb_d = 1'b0;
                        p_addr_d = src_q;
                        cnt_d    = '0;
                    end else begin
                        state_d = IDLE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign fault     = fault_q;
    assign remaining = remaining_q;
    assign p_addr    = p_addr_q;
    assign p_w_rb    = p_w_rb_q;
    assign p_acc     = p_acc_q;
    assign p_wdata   = p_wdata_q;
    assign p_req     = p_req_q;

endmodule

// File: tb/tb_bus_dma_initiator.sv
// Directed bench for bus_dma_initiator: a small bus responder with logging plus
// hand-computed expectations for copy, zero-length, misalignment, timeout, bus fault and reset.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef BUS_WIDTH
`define BUS_WIDTH 32
`endif
`ifndef BUS_ACC_CNT
`define BUS_ACC_CNT 3
`endif

module tb_bus_dma_initiator;

    logic        clk = 1'b0;
    logic        rst, start, abort;
    logic [31:0] src_addr, dst_addr;
    logic [15:0] len;
    logic        busy, done, fault;
    logic [15:0] remaining;
    logic [31:0] p_addr;
    logic        p_w_rb;
    logic [1:0]  p_acc;
    logic [31:0] p_wdata;
    logic        p_req;
    logic [31:0] p_rdata;
    logic        p_resp, p_fault;

    // responder control, written only by the main process
    logic        resp_en, man_resp;
    logic [31:0] man_rdata;
    int          fault_read_idx;

    // responder/monitor state, written only by the responder process
    logic [31:0] rd_log [64];
    logic [31:0] wr_addr_log [64];
    logic [31:0] wr_data_log [64];
    int          nr, nw, req_total, done_total, w;
    logic [15:0] last_rem;
    logic [15:0] rem_log [$];

    int n_checks = 0;
    int n_errors = 0;

    bus_dma_initiator #(.TIMEOUT(8), .LEN_W(16)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .fault(fault), .remaining(remaining),
        .p_addr(p_addr), .p_w_rb(p_w_rb), .p_acc(p_acc), .p_wdata(p_wdata),
        .p_req(p_req), .p_rdata(p_rdata), .p_resp(p_resp), .p_fault(p_fault)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Responder acts on the falling edge so the DUT samples stable inputs.
    initial begin
        p_resp = 1'b0; p_fault = 1'b0; p_rdata = '0;
        nr = 0; nw = 0; req_total = 0; done_total = 0; w = 0; last_rem = '0;
        forever begin
            @(negedge clk);
            if (p_req) req_total++;
            if (done) done_total++;
            if (remaining != last_rem) begin
                rem_log.push_back(remaining);
                last_rem = remaining;
            end
            if (!resp_en) begin
                p_resp = man_resp; p_rdata = man_rdata; p_fault = 1'b0; w = 0;
            end else if (p_resp) begin
                p_resp = 1'b0; p_fault = 1'b0; w = 0;
            end else if (p_req) begin
                if (w == 1) begin
                    p_resp = 1'b1;
                    if (p_w_rb) begin
                        if (nw < 64) begin wr_addr_log[nw] = p_addr; wr_data_log[nw] = p_wdata; end
                        nw++;
                    end else begin
                        if (nr < 64) rd_log[nr] = p_addr;
                        p_rdata = 32'hA5A5_0000 + ((p_addr - 32'h100) >> 2) + 1;
                        p_fault = (nr == fault_read_idx);
                        nr++;
                    end
                end else begin
                    w++;
                end
            end else begin
                w = 0;
            end
        end
    end

    initial begin
        int n, rb, wb, qb, req_b, done_b;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len = '0;
        resp_en = 1'b0; man_resp = 1'b0; man_rdata = '0; fault_read_idx = -1;
        tick(); tick();
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_fault", fault, 0);
        check_eq("rst_remaining", remaining, 0);
        check_eq("rst_p_req", p_req, 0);
        check_eq("rst_p_addr", p_addr, 0);
        check_eq("rst_p_wdata", p_wdata, 0);
        check_eq("rst_p_acc", p_acc, 0);
        check_eq("rst_p_w_rb", p_w_rb, 0);
        rst = 1'b0;
        tick();

        // two-word copy, 1-cycle responder: 6 cycles per word
        resp_en = 1'b1;
        rb = nr; wb = nw; qb = rem_log.size(); done_b = done_total;
        start = 1'b1; src_addr = 32'h100; dst_addr = 32'h200; len = 16'd2;
        tick();
        start = 1'b0;
        check_eq("cp_busy", busy, 1);
        check_eq("cp_remaining", remaining, 2);
        check_eq("cp_p_req", p_req, 1);
        check_eq("cp_p_addr", p_addr, 32'h100);
        check_eq("cp_p_acc", p_acc, 2);
        check_eq("cp_p_w_rb", p_w_rb, 0);
        n = 0;
        while (!done && n < 40) begin tick(); n++; end
        check_eq("cp_cycles", n, 12);
        check_eq("cp_done_busy", busy, 0);
        check_eq("cp_done_rem", remaining, 0);
        tick();
        check_eq("cp_done_clear", done, 0);
        check_eq("cp_done_pulses", done_total - done_b, 1);
        check_eq("cp_nreads", nr - rb, 2);
        check_eq("cp_nwrites", nw - wb, 2);
        check_eq("cp_rd0", rd_log[rb], 32'h100);
        check_eq("cp_rd1", rd_log[rb+1], 32'h104);
        check_eq("cp_wa0", wr_addr_log[wb], 32'h200);
        check_eq("cp_wd0", wr_data_log[wb], 32'hA5A5_0001);
        check_eq("cp_wa1", wr_addr_log[wb+1], 32'h204);
        check_eq("cp_wd1", wr_data_log[wb+1], 32'hA5A5_0002);
        check_eq("cp_rem_steps", rem_log.size() - qb, 3);
        if (rem_log.size() >= qb + 3) begin
            check_eq("cp_rem0", rem_log[qb], 2);
            check_eq("cp_rem1", rem_log[qb+1], 1);
            check_eq("cp_rem2", rem_log[qb+2], 0);
        end

        // zero length
        req_b = req_total;
        start = 1'b1; src_addr = 32'h100; dst_addr = 32'h200; len = 16'd0;
        tick();
        start = 1'b0;
        check_eq("z_done", done, 1);
        check_eq("z_busy", busy, 0);
        tick();
        check_eq("z_done_clear", done, 0);
        check_eq("z_no_req", req_total - req_b, 0);

        // misaligned source, start ignored in ERR, abort recovers
        req_b = req_total;
        start = 1'b1; src_addr = 32'h102; dst_addr = 32'h200; len = 16'd1;
        tick();
        check_eq("mis_fault", fault, 1);
        check_eq("mis_busy", busy, 0);
        src_addr = 32'h100;
        tick();
        start = 1'b0;
        check_eq("mis_ign_busy", busy, 0);
        check_eq("mis_ign_fault", fault, 1);
        check_eq("mis_no_req", req_total - req_b, 0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("mis_abort_fault", fault, 0);
        start = 1'b1; len = 16'd0;
        tick();
        start = 1'b0;
        check_eq("mis_idle_done", done, 1);
        tick();

        // timeout: responder silent, TIMEOUT=8
        resp_en = 1'b0;
        start = 1'b1; src_addr = 32'h300; dst_addr = 32'h400; len = 16'd5;
        tick();
        start = 1'b0;
        n = 0;
        while (p_req && n < 20) begin tick(); n++; end
        check_eq("to_req_cycles", n, 8);
        check_eq("to_fault", fault, 1);
        check_eq("to_busy", busy, 0);
        check_eq("to_remaining", remaining, 5);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check_eq("to_abort_fault", fault, 0);

        // bus fault on second read of a 3-word copy
        resp_en = 1'b1;
        rb = nr; wb = nw;
        fault_read_idx = nr + 1;
        start = 1'b1; src_addr = 32'h100; dst_addr = 32'h600; len = 16'd3;
        tick();
        start = 1'b0;
        n = 0;
        while (!fault && n < 40) begin tick(); n++; end
        tick(); tick();
        check_eq("bf_fault", fault, 1);
        check_eq("bf_remaining", remaining, 2);
        check_eq("bf_p_req", p_req, 0);
        check_eq("bf_busy", busy, 0);
        check_eq("bf_nreads", nr - rb, 2);
        check_eq("bf_nwrites", nw - wb, 1);
        check_eq("bf_wa0", wr_addr_log[wb], 32'h600);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        fault_read_idx = -1;

        // reset during WR, late response ignored
        resp_en = 1'b0;
        start = 1'b1; src_addr = 32'h700; dst_addr = 32'h800; len = 16'd2;
        tick();
        start = 1'b0;
        man_rdata = 32'h1234_5678; man_resp = 1'b1;
        tick();
        man_resp = 1'b0;
        tick();
        check_eq("rw_p_req", p_req, 1);
        check_eq("rw_p_w_rb", p_w_rb, 1);
        check_eq("rw_p_addr", p_addr, 32'h800);
        check_eq("rw_p_wdata", p_wdata, 32'h1234_5678);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rw_p_req0", p_req, 0);
        check_eq("rw_busy0", busy, 0);
        check_eq("rw_rem0", remaining, 0);
        check_eq("rw_addr0", p_addr, 0);
        check_eq("rw_wdata0", p_wdata, 0);
        check_eq("rw_w_rb0", p_w_rb, 0);
        man_resp = 1'b1;
        tick();
        man_resp = 1'b0;
        tick();
        check_eq("late_p_req", p_req, 0);
        check_eq("late_busy", busy, 0);
        check_eq("late_done", done, 0);
        check_eq("late_rem", remaining, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
